usi_spi_resp: RTL

//  FPGA-side SPI responder (slave) on the USI0 pads (NSS/SCLK/SD0/SD1), the far end of the SoC's USI0 SPI master.

---
 rtl/usi_spi_resp.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/usi_spi_resp.sv
// rtl/usi_spi_resp.sv - SPI mode-0 responder with byte register file (optional USI_RESP_FRAME_CNT_EN: reg[DEPTH-1] counts frames)
module usi_spi_resp #(
    parameter int AW   = 4,
    parameter int SYNC = 2
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_b,
    input  logic                    usi_sclk,
    input  logic                    usi_nss,
    input  logic                    usi_mosi,
    output logic                    usi_miso,
    output logic                    usi_miso_oe,
    output logic [8*(2**AW)-1:0]    reg_flat,
    output logic                    wr_vld,
    output logic [AW-1:0]           wr_addr,
    output logic [7:0]              wr_data,
    output logic                    busy
);

    localparam int DEPTH = 2**AW;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CMD     = 2'd1,
        S_WR_DATA = 2'd2,
        S_RD_DATA = 2'd3
    } state_t;

    logic [SYNC-1:0] r_sclk_sh;
    logic [SYNC-1:0] r_nss_sh;
    logic [SYNC-1:0] r_mosi_sh;
    logic            r_sclk_prev;
    logic            r_nss_filt;

    state_t          r_state;
    logic [2:0]      r_bit_cnt;
    logic [6:0]      r_shift;
    logic [7:0]      r_tx;
    logic [AW-1:0]   r_addr;
    logic [7:0]      r_regs [DEPTH];
    logic            r_miso;
    logic            r_busy;
    logic            r_wr_vld;
    logic [AW-1:0]   r_wr_addr;
    logic [7:0]      r_wr_data;
`ifdef USI_RESP_FRAME_CNT_EN
    logic            r_cmd_done;
`endif

    logic            w_sclk_rise;
    logic            w_sclk_fall;
    logic            w_nss_rise;
    logic            w_nss_fall;
    logic            w_mosi;
    logic [7:0]      w_byte;
    logic [AW-1:0]   w_addr_nxt;
    logic            w_wr_ok;

    // Pad synchronizers; NSS level only changes once every stage agrees, which filters short glitches
    always_ff @(posedge sys_clk or negedge sys_rst_b) begin
        if (!sys_rst_b) begin
            r_sclk_sh   <= '0;
            r_nss_sh    <= '1;
            r_mosi_sh   <= '0;
            r_sclk_prev <= 1'b0;
            r_nss_filt  <= 1'b1;
        end else begin
            r_sclk_sh   <= {r_sclk_sh[SYNC-2:0], usi_sclk};
            r_nss_sh    <= {r_nss_sh[SYNC-2:0], usi_nss};
            r_mosi_sh   <= {r_mosi_sh[SYNC-2:0], usi_mosi};
            r_sclk_prev <= r_sclk_sh[SYNC-1];
            if (&r_nss_sh)
                r_nss_filt <= 1'b1;
            else if (~|r_nss_sh)
                r_nss_filt <= 1'b0;
        end
    end

    assign w_sclk_rise = r_sclk_sh[SYNC-1] & ~r_sclk_prev;
    assign w_sclk_fall = ~r_sclk_sh[SYNC-1] & r_sclk_prev;
    assign w_nss_rise  = ~r_nss_filt & (&r_nss_sh);
    assign w_nss_fall  = r_nss_filt & ~(|r_nss_sh);
    assign w_mosi      = r_mosi_sh[SYNC-1];
    assign w_byte      = {r_shift, w_mosi};
    assign w_addr_nxt  = r_addr + 1'b1;
`ifdef USI_RESP_FRAME_CNT_EN
    assign w_wr_ok     = (r_addr != AW'(DEPTH-1));
`else
    assign w_wr_ok     = 1'b1;
`endif

    // Frame FSM: command decode, write commit, burst read shifting, frame counting
    always_ff @(posedge sys_clk or negedge sys_rst_b) begin
        if (!sys_rst_b) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 7'd0;
            r_tx      <= 8'd0;
            r_addr    <= '0;
            r_miso    <= 1'b0;
            r_busy    <= 1'b0;
            r_wr_vld  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 8'd0;
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= 8'd0;
`ifdef USI_RESP_FRAME_CNT_EN
            r_cmd_done <= 1'b0;
`endif
        end else begin
            r_wr_vld <= 1'b0;
            if (w_nss_rise) begin
                r_state   <= S_IDLE;
                r_busy    <= 1'b0;
                r_miso    <= 1'b0;
                r_bit_cnt <= 3'd0;
`ifdef USI_RESP_FRAME_CNT_EN
                if (r_cmd_done) r_regs[DEPTH-1] <= r_regs[DEPTH-1] + 8'd1;
                r_cmd_done <= 1'b0;
`endif
            end else if (w_nss_fall) begin
                r_state   <= S_CMD;
                r_busy    <= 1'b1;
                r_miso    <= 1'b0;
                r_bit_cnt <= 3'd0;
                r_tx      <= 8'd0;
`ifdef USI_RESP_FRAME_CNT_EN
                r_cmd_done <= 1'b0;
`endif
            end else begin
                case (r_state)
                    S_CMD: begin
                        if (w_sclk_rise) begin
                            r_shift   <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_addr <= w_byte[AW-1:0];
`ifdef USI_RESP_FRAME_CNT_EN
                                r_cmd_done <= 1'b1;
`endif
                                if (w_byte[7]) begin
                                    r_state <= S_RD_DATA;
                                    r_tx    <= r_regs[w_byte[AW-1:0]];
                                end else begin
                                    r_state <= S_WR_DATA;
                                end
                            end
                        end
                    end
                    S_WR_DATA: begin
                        if (w_sclk_rise) begin
                            r_shift   <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                if (w_wr_ok) begin
                                    r_regs[r_addr] <= w_byte;
                                    r_wr_vld       <= 1'b1;
                                    r_wr_addr      <= r_addr;
                                    r_wr_data      <= w_byte;
                                end
                                r_addr <= w_addr_nxt;
                            end
                        end
                    end
                    S_RD_DATA: begin
                        if (w_sclk_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_addr <= w_addr_nxt;
                                r_tx   <= r_regs[w_addr_nxt];
                            end
                        end else if (w_sclk_fall) begin
                            r_miso <= r_tx[7];
                            r_tx   <= {r_tx[6:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_flat
            assign reg_flat[8*gi +: 8] = r_regs[gi];
        end
    endgenerate

    assign usi_miso    = r_miso;
    assign usi_miso_oe = r_busy;
    assign busy        = r_busy;
    assign wr_vld      = r_wr_vld;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;

endmodule
